float_mul_iter: RTL and testbench

Iterative IEEE-754 single-precision multiplier with a parametrised number of multiplier bits retired per cycle. It is the successor to the one-bit-per-cycle float multiplier. It adds round-to-nearest-even, exponent overflow/underflow handling, special-value handling and an explicit `ready` handshake. It sits in the GPU core's float unit beside the float adder and is driven by the core's issue logic through a req/ack pair.

---
 rtl/float_pkg.sv | 25 ++
 rtl/float_mul_step.sv | 30 +++
 rtl/float_mul_iter.sv | 213 +++++++++++++++++++++
 tb/tb_float_mul_iter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : float_pkg
//  Brief    : Shared single-precision float constants and multiplier FSM
//             state encoding for the GPU float unit.
//  Revision : 1.0 - initial release
// ============================================================================
package float_pkg;

  localparam int float_width      = 32;
  localparam int float_exp_width  = 8;
  localparam int float_mant_width = 23;
  localparam int FLOAT_BIAS       = 127;

  localparam logic [31:0] FLOAT_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } e_float_mul_state;

endpackage
`default_nettype wire

// File: rtl/float_mul_step.sv
`default_nettype none
// ============================================================================
//  Module   : float_mul_step
//  Brief    : One iteration of the shift-and-add mantissa multiplier. Adds
//             the partial products for a BITS_PER_CYCLE-wide slice of the
//             multiplier, positioned at bit_offset, into the accumulator.
//  Revision : 1.0 - initial release
// ============================================================================
module float_mul_step #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [47:0]               acc_in,
  input  logic [23:0]               mant_a,
  input  logic [BITS_PER_CYCLE-1:0] mant_b_slice,
  input  logic [4:0]                bit_offset,
  output logic [47:0]               acc_out
);

  // Accumulate shifted copies of mant_a for every set multiplier bit in the slice
  always_comb begin
    acc_out = acc_in;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mant_b_slice[j]) begin
        acc_out = acc_out + (48'(mant_a) << (32'(bit_offset) + j));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/float_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module   : float_mul_iter
//  Brief    : Iterative IEEE-754 single-precision multiplier. Retires
//             BITS_PER_CYCLE multiplier bits per cycle, rounds to nearest
//             even, saturates to inf / flushes to zero on exponent range
//             errors and short-circuits NaN / inf / zero operands.
//  Revision : 1.0 - initial release
// ============================================================================
module float_mul_iter
  import float_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  output logic                   ready,
  input  logic [float_width-1:0] a,
  input  logic [float_width-1:0] b,
  output logic                   ack,
  output logic [float_width-1:0] out
);

  localparam int N_ITER = 24 / BITS_PER_CYCLE;

  generate
    if ((BITS_PER_CYCLE < 1) || (BITS_PER_CYCLE > 24) || ((24 % BITS_PER_CYCLE) != 0)) begin : g_bad_bits_per_cycle
      $error("float_mul_iter: BITS_PER_CYCLE must divide 24");
    end
  endgenerate

  e_float_mul_state r_state;
  e_float_mul_state w_state_next;

  logic        r_sign;
  logic [7:0]  r_exp_a;
  logic [7:0]  r_exp_b;
  logic [23:0] r_mant_a;
  logic [23:0] r_mant_b;
  logic [47:0] r_prod;
  logic [4:0]  r_iter;
  logic [31:0] r_special;
  logic [31:0] r_out;
  logic        r_ack;

  logic        w_ack_set;
  logic        w_special_hit;
  logic [31:0] w_special_val;
  logic [4:0]  w_offset;
  logic [BITS_PER_CYCLE-1:0] w_slice;
  logic [47:0] w_acc_next;
  logic [31:0] w_norm_out;

  // Operand classification straight from the request inputs
  logic w_sign;
  logic w_a_nan, w_a_inf, w_a_zero;
  logic w_b_nan, w_b_inf, w_b_zero;

  assign w_sign   = a[31] ^ b[31];
  assign w_a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign w_a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign w_a_zero = (a[30:23] == 8'h00);
  assign w_b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  assign w_b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
  assign w_b_zero = (b[30:23] == 8'h00);

  // Resolve special operands; NaN and inf*0 take priority over inf and zero
  always_comb begin
    w_special_hit = 1'b1;
    w_special_val = 32'd0;
    if (w_a_nan || w_b_nan) begin
      w_special_val = FLOAT_QNAN;
    end else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
      w_special_val = FLOAT_QNAN;
    end else if (w_a_inf || w_b_inf) begin
      w_special_val = {w_sign, 8'hFF, 23'd0};
    end else if (w_a_zero || w_b_zero) begin
      w_special_val = {w_sign, 31'd0};
    end else begin
      w_special_hit = 1'b0;
    end
  end

  // Select the multiplier slice for the current iteration, LSB first
  always_comb begin
    w_offset = 5'(32'(r_iter) * BITS_PER_CYCLE);
    w_slice  = BITS_PER_CYCLE'(r_mant_b >> w_offset);
  end

  float_mul_step #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .acc_in       (r_prod),
    .mant_a       (r_mant_a),
    .mant_b_slice (w_slice),
    .bit_offset   (w_offset),
    .acc_out      (w_acc_next)
  );

  // Normalise, round to nearest even, range check and pack the product
  logic [22:0]       w_mant;
  logic              w_guard;
  logic              w_sticky;
  logic              w_exp_adj;
  logic              w_round;
  logic [23:0]       w_mant_rnd;
  logic signed [9:0] w_exp;

  always_comb begin
    if (r_prod[47]) begin
      w_mant    = r_prod[46:24];
      w_guard   = r_prod[23];
      w_sticky  = |r_prod[22:0];
      w_exp_adj = 1'b1;
    end else begin
      w_mant    = r_prod[45:23];
      w_guard   = r_prod[22];
      w_sticky  = |r_prod[21:0];
      w_exp_adj = 1'b0;
    end
    w_round    = w_guard & (w_sticky | w_mant[0]);
    w_mant_rnd = {1'b0, w_mant} + {23'd0, w_round};
    // A carry out of the rounded mantissa leaves the field at zero and bumps the exponent
    w_exp      = $signed({2'b00, r_exp_a}) + $signed({2'b00, r_exp_b})
               - 10'sd127
               + $signed({9'd0, w_exp_adj})
               + $signed({9'd0, w_mant_rnd[23]});
    if (w_exp >= 10'sd255) begin
      w_norm_out = {r_sign, 8'hFF, 23'd0};
    end else if (w_exp <= 10'sd0) begin
      w_norm_out = {r_sign, 31'd0};
    end else begin
      w_norm_out = {r_sign, w_exp[7:0], w_mant_rnd[22:0]};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (req) w_state_next = w_special_hit ? DONE : MUL;
      MUL:  if (r_iter == 5'(N_ITER - 1)) w_state_next = NORM;
      NORM: w_state_next = IDLE;
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode: ready while idle, ack scheduled on the result-producing states
  always_comb begin
    ready     = (r_state == IDLE);
    w_ack_set = (r_state == NORM) || (r_state == DONE);
  end

  assign ack = r_ack;
  assign out = r_out;

  // Operand capture, product accumulation and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sign    <= 1'b0;
      r_exp_a   <= 8'd0;
      r_exp_b   <= 8'd0;
      r_mant_a  <= 24'd0;
      r_mant_b  <= 24'd0;
      r_prod    <= 48'd0;
      r_iter    <= 5'd0;
      r_special <= 32'd0;
      r_out     <= 32'd0;
      r_ack     <= 1'b0;
    end else begin
      r_ack <= w_ack_set;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_sign    <= w_sign;
            r_exp_a   <= a[30:23];
            r_exp_b   <= b[30:23];
            r_mant_a  <= {1'b1, a[22:0]};
            r_mant_b  <= {1'b1, b[22:0]};
            r_prod    <= 48'd0;
            r_iter    <= 5'd0;
            r_special <= w_special_val;
          end
        end
        MUL: begin
          r_prod <= w_acc_next;
          r_iter <= r_iter + 5'd1;
        end
        default: ;
      endcase
      if (r_state == NORM) begin
        r_out <= w_norm_out;
      end else if (r_state == DONE) begin
        r_out <= r_special;
      end else begin
        r_out <= 32'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_float_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_float_mul_iter
//  Brief    : Self-checking bench for float_mul_iter at BITS_PER_CYCLE of
//             1, 4 and 24 (one instance each, sharing clock and reset).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_float_mul_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_s   [3];
  logic [31:0] a_s     [3];
  logic [31:0] b_s     [3];
  logic [31:0] out_s   [3];
  logic        ready_s [3];
  logic        ack_s   [3];
  int          ack_cnt [3];

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    bit          special;
  } vec_t;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      float_mul_iter #(
        .BITS_PER_CYCLE((gi == 0) ? 1 : ((gi == 1) ? 4 : 24))
      ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req_s[gi]),
        .ready (ready_s[gi]),
        .a     (a_s[gi]),
        .b     (b_s[gi]),
        .ack   (ack_s[gi]),
        .out   (out_s[gi])
      );
    end
  endgenerate

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ack_s[i] === 1'b1) ack_cnt[i]++;
    end
  end

  function automatic int n_iter(input int d);
    return (d == 0) ? 24 : ((d == 1) ? 6 : 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request for one cycle; operands are scrambled after capture
  task automatic start(input int d, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    req_s[d] = 1'b1;
    a_s[d]   = av;
    b_s[d]   = bv;
    @(posedge clk);
    #1;
    req_s[d] = 1'b0;
    a_s[d]   = $urandom;
    b_s[d]   = $urandom;
  endtask

  // Wait for ack; lat is the edge count after capture, -1 on timeout
  task automatic wait_ack(input int d, output int lat, output bit ready_low_ok);
    lat = -1;
    ready_low_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ack_s[d] === 1'b1) begin
        lat = c - 1;
        break;
      end
      if (ready_s[d] !== 1'b0) ready_low_ok = 1'b0;
    end
  endtask

  task automatic run_one(input int d, input int idx, input vec_t v);
    int lat;
    bit rl;
    logic [31:0] exp_v;
    int exp_lat;
    start(d, v.a, v.b);
    sb.push_back(v.exp_out);
    wait_ack(d, lat, rl);
    exp_lat = v.special ? 1 : n_iter(d) + 1;
    if (lat < 0) begin
      failures++;
      checks++;
      $display("FAIL ack_timeout d=%0d v=%0d: got no ack expected latency %0d", d, idx, exp_lat);
      void'(sb.pop_front());
    end else begin
      exp_v = sb.pop_front();
      check($sformatf("latency d=%0d v=%0d", d, idx), 32'(lat), 32'(exp_lat));
      check($sformatf("ready_low d=%0d v=%0d", d, idx), {31'd0, rl}, 32'd1);
      check($sformatf("ready_at_ack d=%0d v=%0d", d, idx), {31'd0, ready_s[d]}, 32'd1);
      check($sformatf("out d=%0d v=%0d", d, idx), out_s[d], exp_v);
      @(negedge clk);
      check($sformatf("ack_pulse d=%0d v=%0d", d, idx), {31'd0, ack_s[d]}, 32'd0);
      check($sformatf("out_cleared d=%0d v=%0d", d, idx), out_s[d], 32'd0);
    end
  endtask

  initial begin
    vec_t vecs[12];
    int lat;
    bit rl;
    int base;

    vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 1'b0};
    vecs[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0};
    vecs[2]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0};
    vecs[3]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0};
    vecs[4]  = '{32'h00000000, 32'h40400000, 32'h00000000, 1'b1};
    vecs[5]  = '{32'h80000000, 32'h40400000, 32'h80000000, 1'b1};
    vecs[6]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b0};
    vecs[7]  = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0};
    vecs[8]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1};
    vecs[9]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b1};
    vecs[10] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b1};
    vecs[11] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0};

    for (int i = 0; i < 3; i++) begin
      req_s[i]   = 1'b0;
      a_s[i]     = 32'd0;
      b_s[i]     = 32'd0;
      ack_cnt[i] = 0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_ready d=%0d", d), {31'd0, ready_s[d]}, 32'd1);
      check($sformatf("rst_ack d=%0d", d), {31'd0, ack_s[d]}, 32'd0);
      check($sformatf("rst_out d=%0d", d), out_s[d], 32'd0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven vectors on every configuration
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 12; i++) begin
        run_one(d, i, vecs[i]);
      end
    end

    // A request raised during MUL is neither accepted nor queued
    for (int d = 0; d < 2; d++) begin
      base = ack_cnt[d];
      start(d, 32'h40000000, 32'h40400000);
      sb.push_back(32'h40C00000);
      @(negedge clk);
      req_s[d] = 1'b1;
      a_s[d]   = 32'h3FC00000;
      b_s[d]   = 32'h3FC00000;
      @(negedge clk);
      req_s[d] = 1'b0;
      wait_ack(d, lat, rl);
      if (lat < 0) begin
        failures++;
        checks++;
        $display("FAIL busy_req_timeout d=%0d: got no ack expected one", d);
        void'(sb.pop_front());
      end else begin
        check($sformatf("busy_req_out d=%0d", d), out_s[d], sb.pop_front());
      end
      repeat (30) @(negedge clk);
      check($sformatf("busy_req_ack_count d=%0d", d), 32'(ack_cnt[d] - base), 32'd1);
    end

    // Reset in the middle of MUL aborts without ack
    base = ack_cnt[0];
    start(0, 32'h40000000, 32'h40400000);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'd0, ready_s[0]}, 32'd1);
    check("abort_out", out_s[0], 32'd0);
    rst = 1'b1;
    repeat (35) @(negedge clk);
    check("abort_no_ack", 32'(ack_cnt[0] - base), 32'd0);
    check("abort_ready_after", {31'd0, ready_s[0]}, 32'd1);
    run_one(0, 100, vecs[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
